// File: rtl/turfio_wb_arbmux.sv
// Shared-bus Wishbone classic interconnect: round-robin grant among NMASTER masters, address decode to
// NSLAVE slaves, decode-error response. Define TURFIO_WB_TIMEOUT_EN to add a bus-timeout error response.
module turfio_wb_arbmux #(
    parameter int NMASTER   = 4,
    parameter int NSLAVE    = 4,
    parameter int ADR_W     = 22,
    parameter int SLV_ADR_W = 12,
    parameter int DAT_W     = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NMASTER-1:0]          m_cyc_i,
    input  logic [NMASTER-1:0]          m_stb_i,
    input  logic [NMASTER-1:0]          m_we_i,
    input  logic [NMASTER*ADR_W-1:0]    m_adr_i,
    input  logic [NMASTER*DAT_W-1:0]    m_dat_i,
    input  logic [NMASTER*DAT_W/8-1:0]  m_sel_i,
    output logic [NMASTER-1:0]          m_ack_o,
    output logic [NMASTER-1:0]          m_err_o,
    output logic [NMASTER-1:0]          m_rty_o,
    output logic [DAT_W-1:0]            m_dat_o,
    output logic [NSLAVE-1:0]           s_cyc_o,
    output logic [NSLAVE-1:0]           s_stb_o,
    output logic [NSLAVE-1:0]           s_we_o,
    output logic [SLV_ADR_W-1:0]        s_adr_o,
    output logic [DAT_W-1:0]            s_dat_o,
    output logic [DAT_W/8-1:0]          s_sel_o,
    input  logic [NSLAVE-1:0]           s_ack_i,
    input  logic [NSLAVE-1:0]           s_err_i,
    input  logic [NSLAVE-1:0]           s_rty_i,
    input  logic [NSLAVE*DAT_W-1:0]     s_dat_i,
    output logic [NMASTER-1:0]          grant_o
);

    localparam int SEL_W  = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam int MIDX_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int BSEL_W = DAT_W / 8;

    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nxt;

    logic [MIDX_W-1:0]  owner, last, pick, cand;
    logic               pick_vld, load, release_bus;
    logic [NMASTER-1:0] grant;

    logic [ADR_W-1:0]   m_adr  [NMASTER];
    logic [DAT_W-1:0]   m_wdat [NMASTER];
    logic [BSEL_W-1:0]  m_sel  [NMASTER];
    logic [DAT_W-1:0]   s_rdat [NSLAVE];

    logic               own_cyc, own_stb, dec_err, sel_ok, tmo_hit;
    logic [ADR_W-1:0]   own_adr;
    logic [SEL_W-1:0]   slv_idx;

    for (genvar k = 0; k < NMASTER; k++) begin : g_mst
        assign m_adr[k]  = m_adr_i[k*ADR_W +: ADR_W];
        assign m_wdat[k] = m_dat_i[k*DAT_W +: DAT_W];
        assign m_sel[k]  = m_sel_i[k*BSEL_W +: BSEL_W];
    end

    for (genvar j = 0; j < NSLAVE; j++) begin : g_slv
        assign s_rdat[j] = s_dat_i[j*DAT_W +: DAT_W];
    end

    // Round-robin search starts just after the last granted master.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NMASTER; i++) begin
            cand = MIDX_W'((32'(last) + i) % NMASTER);
            if (!pick_vld && m_cyc_i[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        release_bus = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    load      = 1'b1;
                end
            end
            GRANT: begin
                if (!m_cyc_i[owner]) begin
                    state_nxt   = IDLE;
                    release_bus = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            owner <= '0;
            last  <= MIDX_W'(NMASTER - 1);
            grant <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                owner <= pick;
                last  <= pick;
                grant <= NMASTER'(1) << pick;
            end else if (release_bus) begin
                grant <= '0;
            end
        end
    end

    assign grant_o = grant;

    always_comb begin
        own_cyc = (state == GRANT) && m_cyc_i[owner];
        own_stb = own_cyc && m_stb_i[owner];
        own_adr = m_adr[owner];
        slv_idx = own_adr[SLV_ADR_W +: SEL_W];
        dec_err = (32'(slv_idx) >= NSLAVE) || ((own_adr >> (SLV_ADR_W + SEL_W)) != '0);
    end

    always_comb begin
        sel_ok  = own_cyc && !dec_err && !tmo_hit;
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = {NSLAVE{own_cyc & m_we_i[owner]}};
        s_adr_o = own_cyc ? own_adr[SLV_ADR_W-1:0] : '0;
        s_dat_o = own_cyc ? m_wdat[owner] : '0;
        s_sel_o = own_cyc ? m_sel[owner] : '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        m_dat_o = '0;
        if (sel_ok) begin
            s_cyc_o[slv_idx] = 1'b1;
            s_stb_o[slv_idx] = own_stb;
            m_ack_o[owner]   = s_ack_i[slv_idx];
            m_err_o[owner]   = s_err_i[slv_idx];
            m_rty_o[owner]   = s_rty_i[slv_idx];
            m_dat_o          = s_rdat[slv_idx];
        end
        if ((own_stb && dec_err) || tmo_hit)
            m_err_o[owner] = 1'b1;
    end

`ifdef TURFIO_WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] tmo_cnt;
    logic             slv_rsp;

    assign slv_rsp = sel_ok && (s_ack_i[slv_idx] || s_err_i[slv_idx] || s_rty_i[slv_idx]);
    assign tmo_hit = own_stb && (tmo_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            tmo_cnt <= '0;
        else if (!own_stb || slv_rsp || dec_err || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_turfio_wb_arbmux.sv
// Scoreboard bench for turfio_wb_arbmux (NSLAVE=3); the timeout case runs when TURFIO_WB_TIMEOUT_EN is defined.
module tb_turfio_wb_arbmux;
    localparam int NM = 4, NS = 3, AW = 22, SAW = 12, DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0]      m_cyc, m_stb, m_we, m_ack, m_err, m_rty, grant;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [DW-1:0]      m_rdat, s_wdat;
    logic [NS-1:0]      s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [SAW-1:0]     s_adr;
    logic [DW/8-1:0]    s_sel;
    logic [NS*DW-1:0]   s_rdat;

    turfio_wb_arbmux #(.NMASTER(NM), .NSLAVE(NS), .ADR_W(AW), .SLV_ADR_W(SAW), .DAT_W(DW), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty), .m_dat_o(m_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_rdat),
        .grant_o(grant)
    );

    typedef struct {
        int          mst;
        logic [31:0] dat;
        logic        err;
        logic        cd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    int          tick_no = 0;
    logic [31:0] sdat [NS] = '{32'h1111_0000, 32'hDEADBEEF, 32'h5555_0002};
    int          lat  [NS] = '{1, 3, 0};   // 0 = slave never acks
    int          stb_cnt [NS] = '{0, 0, 0};
    logic [NM-1:0] auto_en = '0, hold = '0;
    int          ndone [NM] = '{0, 0, 0, 0};

    logic [NM-1:0]  snap_grant, snap_rsp, snap_err;
    logic [NS-1:0]  snap_s_cyc, snap_s_stb;
    logic [SAW-1:0] snap_s_adr;
    logic [DW-1:0]  snap_s_dat, snap_mdat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One bus cycle: drive auto masters, answer as slaves, snapshot and score responses.
    task automatic tick();
        exp_t e;
        for (int k = 0; k < NM; k++) begin
            if (auto_en[k]) begin
                m_cyc[k] = (ndone[k] < 2) && !hold[k];
                m_stb[k] = m_cyc[k];
                hold[k]  = 1'b0;
            end
        end
        #1;
        for (int j = 0; j < NS; j++)
            s_ack[j] = s_stb[j] && (lat[j] != 0) && (stb_cnt[j] + 1 >= lat[j]);
        #1;
        snap_grant = grant;
        snap_s_cyc = s_cyc;
        snap_s_stb = s_stb;
        snap_s_adr = s_adr;
        snap_s_dat = s_wdat;
        snap_mdat  = m_rdat;
        snap_rsp   = m_ack | m_err | m_rty;
        snap_err   = m_err;
        if (snap_rsp != '0) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 32'(snap_rsp), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_mst", 32'(snap_rsp), 32'd1 << e.mst);
                chk("rsp_err", 32'(|m_err), 32'(e.err));
                if (e.cd) chk("rsp_dat", m_rdat, e.dat);
            end
            for (int k = 0; k < NM; k++) begin
                if (auto_en[k] && snap_rsp[k]) begin
                    ndone[k]++;
                    hold[k] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NS; j++)
            stb_cnt[j] = (s_stb[j] && !s_ack[j]) ? stb_cnt[j] + 1 : 0;
        @(negedge clk);
        tick_no++;
    endtask

    task automatic txn(input int k, input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] wd,
                       input logic err, input logic [DW-1:0] rd, input logic cd, output int n);
        sb.push_back('{k, rd, err, cd});
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = wd;
        m_we[k]  = we;
        m_cyc[k] = 1'b1;
        m_stb[k] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!snap_rsp[k] && n < 60);
        if (!snap_rsp[k]) chk("txn_bound", 32'd0, 32'd1);
        if (err) chk("err_no_stb", 32'(snap_s_stb), 32'd0);
        else if (we) chk("wr_dat", snap_s_dat, wd);
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
        m_we[k]  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required completion");
        $fatal(1);
    end

    initial begin
        int n, t, first, nseq, noidle;
        logic [NM-1:0] prev;
        logic [NM-1:0] seq [6];
        int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '1;
        s_ack = '0; s_err = '0; s_rty = '0;
        s_rdat = {sdat[2], sdat[1], sdat[0]};
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_mrsp", 32'(m_ack | m_err | m_rty), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round robin among masters 0,1,3, each doing two reads then stopping.
        m_adr[0*AW +: AW] = 22'h000020;
        m_adr[1*AW +: AW] = 22'h001020;
        m_adr[3*AW +: AW] = 22'h000030;
        for (int i = 0; i < 6; i++) sb.push_back('{rr_exp[i], sdat[rr_exp[i] % 3], 1'b0, 1'b1});
        auto_en = 4'b1011;
        prev = '0; nseq = 0; noidle = 0;
        for (int c = 0; c < 200 && (ndone[0] + ndone[1] + ndone[3] < 6); c++) begin
            tick();
            if (snap_grant != '0 && snap_grant != prev) begin
                if (prev != '0) noidle++;
                if (nseq < 6) seq[nseq] = snap_grant;
                nseq++;
            end
            prev = snap_grant;
        end
        chk("rr_count", 32'(nseq), 32'd6);
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(seq[i]), 32'd1 << rr_exp[i]);
        chk("rr_idle_gap", 32'(noidle), 32'd0);
        auto_en = '0; m_cyc = '0; m_stb = '0;
        tick();
        tick();

        // Master 2 reads slave 1, which acks on its third strobed cycle.
        m_adr[2*AW +: AW] = 22'h001004;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        sb.push_back('{2, 32'hDEADBEEF, 1'b0, 1'b1});
        tick();
        chk("t1_pre_grant", 32'(snap_grant), 32'd0);
        chk("t1_pre_scyc", 32'(snap_s_cyc), 32'd0);
        chk("t1_idle_dat", snap_mdat, 32'd0);
        tick();
        chk("t1_grant", 32'(snap_grant), 32'b0100);
        chk("t1_scyc", 32'(snap_s_cyc), 32'b010);
        chk("t1_sadr", 32'(snap_s_adr), 32'h004);
        n = 1;
        while (!snap_rsp[2] && n < 20) begin
            tick();
            n++;
        end
        chk("t1_ack_cycle", 32'(n), 32'd3);
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        tick();
        chk("t1_rel_scyc", 32'(snap_s_cyc), 32'd0);
        chk("t1_rel_grant", 32'(snap_grant), 32'b0100);
        tick();
        chk("t1_idle_grant", 32'(snap_grant), 32'd0);

        // Decode errors (upper address bits, slave index out of range) and a valid write.
        txn(0, 22'h200000, 1'b1, 32'h12345678, 1'b1, 32'd0, 1'b1, n);
        chk("dec_hi_lat", 32'(n), 32'd2);
        txn(3, 22'h003000, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, n);
        chk("dec_idx_lat", 32'(n), 32'd2);
        txn(1, 22'h000010, 1'b1, 32'hCAFEF00D, 1'b0, sdat[0], 1'b1, n);
        chk("wr_lat", 32'(n), 32'd2);

        // Asynchronous reset while master 1 owns the bus on a silent slave.
        m_adr[1*AW +: AW] = 22'h002000;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        tick();
        tick();
        chk("rst_pre_grant", 32'(snap_grant), 32'b0010);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_grant", 32'(grant), 32'd0);
        chk("rst_async_scyc", 32'(s_cyc), 32'd0);
        m_cyc[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_idle", 32'(snap_grant), 32'd0);
        tick();
        chk("rst_m0_first", 32'(snap_grant), 32'b0001);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

`ifdef TURFIO_WB_TIMEOUT_EN
        // Slave 2 never answers: one-cycle error after 16 strobed cycles.
        sb.push_back('{2, 32'd0, 1'b1, 1'b0});
        m_adr[2*AW +: AW] = 22'h002008;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        first = -1; n = 0; t = 0;
        do begin
            t = tick_no;
            tick();
            n++;
            if (first < 0 && snap_s_stb[2]) first = t;
        end while (!snap_rsp[2] && n < 60);
        chk("tmo_lat", 32'(t - first), 32'd16);
        chk("tmo_scyc_low", 32'(snap_s_cyc[2]), 32'd0);
        tick();
        chk("tmo_pulse", 32'(snap_err), 32'd0);
        chk("tmo_resume", 32'(snap_s_stb[2]), 32'd1);
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        tick();
        tick();
`endif

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
